instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 111 +++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch stage with single-outstanding memory request and IF/ID register
module instruction_fetch #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] current_pc,
  output logic        pc_write_enable,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out,
  output logic        instr_valid
);

  // FETCH issues a request, WAIT holds it until the ack, HOLD presents the
  // captured instruction to decode until it is consumed or flushed.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state;

  // One-cycle pulse in the first HOLD cycle; lets the PC register step
  // exactly once per accepted instruction.
  logic advance;

  // Set when a redirect arrives while a request is in flight. The response
  // must still be drained (only one request may be outstanding) but its
  // data belongs to the wrong path and is dropped.
  logic discard;

  // The PC register advances after a capture, or loads the redirect target
  // in the same cycle flush is raised.
  assign pc_write_enable = advance | flush;

  // Fetch control FSM with registered memory interface and IF/ID outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      imem_req     <= 1'b0;
      imem_addr    <= 32'h0000_0000;
      instr_out    <= NOP_INSTR;
      pc_plus4_out <= 32'h0000_0000;
      instr_valid  <= 1'b0;
      advance      <= 1'b0;
      discard      <= 1'b0;
    end else begin
      advance <= 1'b0;
      case (state)
        FETCH: begin
          // A stalled decode or a redirect in progress means current_pc is
          // not the address we want yet; wait for a quiet cycle.
          if (!stall && !flush) begin
            imem_addr <= current_pc;
            imem_req  <= 1'b1;
            state     <= WAIT;
          end
        end

        WAIT: begin
          // Request and address stay frozen here; stall has no effect since
          // nothing is presented to decode yet.
          if (imem_ack) begin
            imem_req <= 1'b0;
            discard  <= 1'b0;
            if (discard || flush) begin
              state <= FETCH;
            end else begin
              instr_out    <= imem_rdata;
              pc_plus4_out <= imem_addr + 32'd4;
              instr_valid  <= 1'b1;
              advance      <= 1'b1;
              state        <= HOLD;
            end
          end else if (flush) begin
            discard <= 1'b1;
          end
        end

        HOLD: begin
          // A redirect wins over a stall: the held instruction is on the
          // wrong path regardless of whether decode could take it.
          if (flush) begin
            instr_valid <= 1'b0;
            instr_out   <= NOP_INSTR;
            state       <= FETCH;
          end else if (!stall) begin
            // Decode takes the instruction this cycle; present a bubble.
            instr_valid <= 1'b0;
            instr_out   <= NOP_INSTR;
            state       <= FETCH;
          end
        end

        default: begin
          state    <= FETCH;
          imem_req <= 1'b0;
          discard  <= 1'b0;
        end
      endcase
    end
  end

endmodule
